// File: rtl/ro_puf_eval.sv
// ro_puf_eval: ring-oscillator PUF evaluator.
// For each of RESP_W challenge pairs, enables the two selected oscillators,
// counts their synchronised rising edges over a WINDOW-cycle window after
// SETTLE cycles of warm-up, and records whether the first one counted more.
// Optional feature macro: RO_PUF_MARGIN_EN (per-bit stability flag from the
// count difference versus MARGIN). When undefined, stable goes all-ones at DONE.
module ro_puf_eval #(
  parameter int NUM_RO = 16,
  parameter int SEL_W  = 4,
  parameter int RESP_W = 4,
  parameter int CNT_W  = 16,
  parameter int WINDOW = 4096,
  parameter int SETTLE = 16,
  parameter int MARGIN = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      start,
  input  logic [RESP_W*SEL_W-1:0]   cha0,
  input  logic [RESP_W*SEL_W-1:0]   cha1,
  input  logic [NUM_RO-1:0]         ro_in,
  output logic [NUM_RO-1:0]         ro_en,
  output logic                      busy,
  output logic                      valid,
  output logic [RESP_W-1:0]         response,
  output logic                      cfg_err,
  output logic [RESP_W-1:0]         stable
);

  localparam int TMR_MAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
  localparam int TMR_W   = $clog2(TMR_MAX) + 1;
  localparam int IDX_W   = (RESP_W > 1) ? $clog2(RESP_W) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_SETTLE, S_COUNT, S_COMPARE, S_DONE
  } state_t;

  state_t                    state_q, state_d;
  logic [NUM_RO-1:0]         s1_q, s2_q, s3_q;
  logic [NUM_RO-1:0]         rise;
  logic [RESP_W*SEL_W-1:0]   cha0_q, cha0_d, cha1_q, cha1_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [TMR_W-1:0]          tmr_q, tmr_d;
  logic [CNT_W-1:0]          cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic [RESP_W-1:0]         acc_q, acc_d;
  logic [NUM_RO-1:0]         ro_en_q, ro_en_d;
  logic                      busy_q, busy_d, valid_q, valid_d, cfg_err_q, cfg_err_d;
  logic [RESP_W-1:0]         resp_q, resp_d, stable_q, stable_d;
  logic [SEL_W-1:0]          sel0, sel1;
  logic                      pair_ok, e0, e1, stab_bit;
  logic [NUM_RO-1:0]         pair_mask;
`ifdef RO_PUF_MARGIN_EN
  logic [RESP_W-1:0]         sacc_q, sacc_d;
  logic [CNT_W-1:0]          diff;
`endif

  // Two-flop synchroniser plus a third stage for rising-edge detection
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= ro_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise = s2_q & ~s3_q;

  // Decode the current pair: indices, validity, enable mask and edge taps
  always_comb begin
    sel0      = '0;
    sel1      = '0;
    e0        = 1'b0;
    e1        = 1'b0;
    pair_mask = '0;
    for (int unsigned i = 0; i < RESP_W; i++) begin
      if (32'(idx_q) == i) begin
        sel0 = cha0_q[i*SEL_W +: SEL_W];
        sel1 = cha1_q[i*SEL_W +: SEL_W];
      end
    end
    pair_ok = (sel0 != sel1) && (32'(sel0) < NUM_RO) && (32'(sel1) < NUM_RO);
    for (int unsigned k = 0; k < NUM_RO; k++) begin
      if (32'(sel0) == k) e0 = rise[k];
      if (32'(sel1) == k) e1 = rise[k];
      if (pair_ok && (32'(sel0) == k || 32'(sel1) == k)) pair_mask[k] = 1'b1;
    end
`ifdef RO_PUF_MARGIN_EN
    diff     = (cnt0_q >= cnt1_q) ? (cnt0_q - cnt1_q) : (cnt1_q - cnt0_q);
    stab_bit = pair_ok && (diff >= CNT_W'(MARGIN));
`else
    stab_bit = 1'b1;
`endif
  end

  // Next-state and datapath updates; abort overrides every non-IDLE state
  always_comb begin
    state_d   = state_q;
    cha0_d    = cha0_q;
    cha1_d    = cha1_q;
    idx_d     = idx_q;
    tmr_d     = tmr_q;
    cnt0_d    = cnt0_q;
    cnt1_d    = cnt1_q;
    acc_d     = acc_q;
    ro_en_d   = ro_en_q;
    busy_d    = busy_q;
    valid_d   = 1'b0;
    cfg_err_d = cfg_err_q;
    resp_d    = resp_q;
    stable_d  = stable_q;
`ifdef RO_PUF_MARGIN_EN
    sacc_d    = sacc_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start && enable) begin
          cha0_d    = cha0;
          cha1_d    = cha1;
          idx_d     = '0;
          cfg_err_d = 1'b0;
          busy_d    = 1'b1;
          state_d   = S_ARM;
        end
      end
      S_ARM: begin
        cnt0_d  = '0;
        cnt1_d  = '0;
        tmr_d   = '0;
        ro_en_d = pair_mask;
        state_d = (SETTLE == 0) ? S_COUNT : S_SETTLE;
      end
      S_SETTLE: begin
        if (32'(tmr_q) + 1 >= SETTLE) begin
          tmr_d   = '0;
          state_d = S_COUNT;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      S_COUNT: begin
        if (e0 && cnt0_q != '1) cnt0_d = cnt0_q + CNT_W'(1);
        if (e1 && cnt1_q != '1) cnt1_d = cnt1_q + CNT_W'(1);
        if (32'(tmr_q) + 1 >= WINDOW) begin
          tmr_d   = '0;
          state_d = S_COMPARE;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      S_COMPARE: begin
        for (int unsigned i = 0; i < RESP_W; i++) begin
          if (32'(idx_q) == i) begin
            acc_d[i] = pair_ok && (cnt0_q > cnt1_q);
`ifdef RO_PUF_MARGIN_EN
            sacc_d[i] = stab_bit;
`endif
          end
        end
        if (!pair_ok) cfg_err_d = 1'b1;
        ro_en_d = '0;
        if (32'(idx_q) == RESP_W - 1) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_ARM;
        end
      end
      S_DONE: begin
        resp_d = acc_q;
`ifdef RO_PUF_MARGIN_EN
        stable_d = sacc_q;
`else
        stable_d = {RESP_W{stab_bit}};
`endif
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_q != S_IDLE && !enable) begin
      state_d  = S_IDLE;
      ro_en_d  = '0;
      busy_d   = 1'b0;
      valid_d  = 1'b0;
      resp_d   = resp_q;
      stable_d = stable_q;
    end
  end

  // FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Datapath and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cha0_q    <= '0;
      cha1_q    <= '0;
      idx_q     <= '0;
      tmr_q     <= '0;
      cnt0_q    <= '0;
      cnt1_q    <= '0;
      acc_q     <= '0;
      ro_en_q   <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      cfg_err_q <= 1'b0;
      resp_q    <= '0;
      stable_q  <= '0;
`ifdef RO_PUF_MARGIN_EN
      sacc_q    <= '0;
`endif
    end else begin
      cha0_q    <= cha0_d;
      cha1_q    <= cha1_d;
      idx_q     <= idx_d;
      tmr_q     <= tmr_d;
      cnt0_q    <= cnt0_d;
      cnt1_q    <= cnt1_d;
      acc_q     <= acc_d;
      ro_en_q   <= ro_en_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      cfg_err_q <= cfg_err_d;
      resp_q    <= resp_d;
      stable_q  <= stable_d;
`ifdef RO_PUF_MARGIN_EN
      sacc_q    <= sacc_d;
`endif
    end
  end

  assign ro_en    = ro_en_q;
  assign busy     = busy_q;
  assign valid    = valid_q;
  assign response = resp_q;
  assign cfg_err  = cfg_err_q;
  assign stable   = stable_q;

endmodule

// File: tb/tb_ro_puf_eval.sv
// Testbench for ro_puf_eval (default build, RO_PUF_MARGIN_EN undefined).
// Oscillators are square waves with a per-RO half-period in clocks; expected
// responses come from comparing those half-periods and are queued at start.
module tb_ro_puf_eval;

  localparam int LAT = 4 * (2 + 4 + 64) + 1;

  logic        clock = 1'b0;
  logic        reset, enable, start;
  logic [15:0] cha0, cha1;
  logic [15:0] ro_in = '0;
  logic [15:0] ro_en;
  logic        busy, valid, cfg_err;
  logic [3:0]  response, stable;

  int hp[16];
  int rcnt[16];
  int total = 0;
  int bad   = 0;

  typedef struct packed { logic [3:0] resp; logic err; } exp_t;
  exp_t sb[$];

  ro_puf_eval #(
    .NUM_RO(16), .SEL_W(4), .RESP_W(4), .CNT_W(16),
    .WINDOW(64), .SETTLE(4), .MARGIN(8)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .start(start),
    .cha0(cha0), .cha1(cha1), .ro_in(ro_in), .ro_en(ro_en),
    .busy(busy), .valid(valid), .response(response),
    .cfg_err(cfg_err), .stable(stable)
  );

  always #5 clock = ~clock;

  // Square-wave oscillator models
  always @(posedge clock) begin
    for (int k = 0; k < 16; k++) begin
      if (rcnt[k] + 1 >= hp[k]) begin
        ro_in[k] <= ~ro_in[k];
        rcnt[k]  <= 0;
      end else begin
        rcnt[k] <= rcnt[k] + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Run one evaluation; zero_bit selects a pair whose ro_en must stay 0
  task automatic run_eval(input string tag, input logic [15:0] c0, input logic [15:0] c1,
                          input int pulse_at, input int zero_bit);
    exp_t        e, got;
    logic [3:0]  s0, s1;
    logic [15:0] mask0, en10;
    int          n;
    logic        seen, two_hot, en_nz, busy1;
    e.resp = '0;
    e.err  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s0 = c0[i*4 +: 4];
      s1 = c1[i*4 +: 4];
      if (s0 == s1) e.err = 1'b1;
      else e.resp[i] = (hp[s0] < hp[s1]);
    end
    s0 = c0[3:0];
    s1 = c1[3:0];
    mask0 = (s0 == s1) ? 16'h0 : ((16'h1 << s0) | (16'h1 << s1));
    sb.push_back(e);
    @(negedge clock);
    cha0 = c0; cha1 = c1; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    n = 0; seen = 1'b0; two_hot = 1'b0; en_nz = 1'b0; busy1 = 1'b0; en10 = '0;
    while (n < 400 && !seen) begin
      @(posedge clock); #1;
      n++;
      if (n == 1) busy1 = busy;
      if (n == 10) en10 = ro_en;
      if ($countones(ro_en) > 2) two_hot = 1'b1;
      if (zero_bit >= 0 && n > zero_bit*70 && n < zero_bit*70 + 70 && ro_en != 0) en_nz = 1'b1;
      start = (n == pulse_at);
      seen = valid;
    end
    start = 1'b0;
    check({tag, "_latency"}, n, LAT);
    check({tag, "_busy_after_start"}, busy1, 1'b1);
    check({tag, "_ro_en_bit0"}, en10, mask0);
    check({tag, "_ro_en_le_2hot"}, two_hot, 1'b0);
    if (zero_bit >= 0) check({tag, "_ro_en_invalid_pair"}, en_nz, 1'b0);
    check({tag, "_busy_at_valid"}, busy, 1'b0);
    got = sb.pop_front();
    check({tag, "_response"}, response, got.resp);
    check({tag, "_cfg_err"}, cfg_err, got.err);
    check({tag, "_stable"}, stable, 4'hF);
    @(posedge clock); #1;
    check({tag, "_valid_one_cycle"}, valid, 1'b0);
  endtask

  initial begin
    int  n;
    logic saw_valid;
    for (int k = 0; k < 16; k++) begin
      hp[k]   = 6;
      rcnt[k] = 0;
    end
    hp[3] = 2; hp[5] = 4; hp[6] = 3; hp[7] = 5;
    reset = 1'b1; enable = 1'b1; start = 1'b0; cha0 = '0; cha1 = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_ro_en", ro_en, 16'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_valid", valid, 1'b0);
    check("rst_response", response, 4'h0);
    check("rst_cfg_err", cfg_err, 1'b0);
    check("rst_stable", stable, 4'h0);
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // all pairs (3,5)
    run_eval("t1", 16'h3333, 16'h5555, -1, -1);
    // pair 1 is (7,7): invalid
    run_eval("t3", 16'h3373, 16'h5575, -1, 1);
    // alternating pairs, start pulsed while busy
    run_eval("t2", 16'h3535, 16'h5353, 50, -1);

    // abort at cycle 100
    @(negedge clock);
    cha0 = 16'h5555; cha1 = 16'h3333; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (99) @(posedge clock);
    #1;
    enable = 1'b0;
    @(posedge clock); #1;
    check("abort_busy", busy, 1'b0);
    check("abort_ro_en", ro_en, 16'h0);
    enable = 1'b1;
    saw_valid = 1'b0;
    n = 0;
    while (n < 300) begin
      @(posedge clock); #1;
      n++;
      if (valid) saw_valid = 1'b1;
    end
    check("abort_no_valid", saw_valid, 1'b0);
    check("abort_response_kept", response, 4'b1010);
    check("abort_stable_kept", stable, 4'hF);
    check("abort_idle_busy", busy, 1'b0);

    // reset mid-COUNT
    @(negedge clock);
    cha0 = 16'h3333; cha1 = 16'h5555; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (30) @(posedge clock);
    #1;
    check("pre_reset_busy", busy, 1'b1);
    reset = 1'b1;
    #1;
    check("midrst_ro_en", ro_en, 16'h0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_response", response, 4'h0);
    check("midrst_stable", stable, 4'h0);
    check("midrst_cfg_err", cfg_err, 1'b0);
    check("midrst_valid", valid, 1'b0);
    sb.delete();
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    run_eval("t6", 16'h3333, 16'h5555, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
